// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, constant instruction ROM, next-PC
// selection from decode-stage redirect fields, and the F/D pipeline register.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h00003000,
    parameter int          IM_DEPTH = 1024,
    // ROM image supplied as a parameter so the array folds into constant logic.
    parameter logic [31:0] IM_INIT [IM_DEPTH] = '{default: 32'h0}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] f_pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8
);

    localparam int          AW       = $clog2(IM_DEPTH);
    localparam logic [31:0] IM_BYTES = 32'(4 * IM_DEPTH);

    logic [31:0] f_pc_reg;
    logic [31:0] d_instr_reg;
    logic [31:0] d_pc_reg;
    logic [31:0] d_pc8_reg;

    logic [31:0] rom [IM_DEPTH];

    for (genvar gi = 0; gi < IM_DEPTH; gi++) begin : g_rom
        assign rom[gi] = IM_INIT[gi];
    end

    // Offset from the ROM base; a wrapped subtraction lands far above IM_BYTES,
    // so one unsigned compare covers both ends of the window.
    logic [31:0]   f_off;
    logic          f_hit;
    logic [AW-1:0] f_idx;
    logic [31:0]   f_instr;

    assign f_off   = f_pc_reg - PC_RESET;
    assign f_hit   = (f_off < IM_BYTES) && (f_off[1:0] == 2'b00);
    assign f_idx   = f_off[AW+1:2];
    assign f_instr = f_hit ? rom[f_idx] : 32'h0;

    logic [31:0] d_pc4;
    logic [31:0] br_disp;
    logic [31:0] pc_next;

    assign d_pc4   = d_pc_reg + 32'd4;
    assign br_disp = {{14{br_off[15]}}, br_off, 2'b00};

    always_comb begin
        pc_next = f_pc_reg + 32'd4;
        unique case (npc_op)
            2'b01:   if (br_taken) pc_next = d_pc4 + br_disp;
            2'b10:   pc_next = {d_pc4[31:28], j_index, 2'b00};
            2'b11:   pc_next = jr_target;
            default: pc_next = f_pc_reg + 32'd4;
        endcase
    end

    // Stall dominates flush; a flushed slot still carries its PC forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_reg    <= PC_RESET;
            d_instr_reg <= 32'h0;
            d_pc_reg    <= PC_RESET;
            d_pc8_reg   <= PC_RESET + 32'd8;
        end else if (!stall) begin
            f_pc_reg    <= pc_next;
            d_instr_reg <= flush ? 32'h0 : f_instr;
            d_pc_reg    <= f_pc_reg;
            d_pc8_reg   <= f_pc_reg + 32'd8;
        end
    end

    assign f_pc    = f_pc_reg;
    assign d_instr = d_instr_reg;
    assign d_pc    = d_pc_reg;
    assign d_pc8   = d_pc8_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model of the fetch rules is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h00003000;

    localparam logic [31:0] TB_ROM [1024] = '{
        0: 32'h3c010001, 1: 32'h34210002, 2: 32'h00000000, 3: 32'h1000fffe,
        4: 32'h24000004, 5: 32'h24000005, 6: 32'h24000006, 7: 32'h24000007,
        8: 32'h24000008, 9: 32'h24000009, 10: 32'h2400000a, 11: 32'h2400000b,
        12: 32'h2400000c, 13: 32'h2400000d, 14: 32'h2400000e, 15: 32'h2400000f,
        16: 32'h24000010, 17: 32'h24000011, 1023: 32'hdeadbeef,
        default: 32'h0
    };

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken;
    logic [1:0]  npc_op;
    logic [15:0] br_off;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] f_pc, d_instr, d_pc, d_pc8;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    fetch_stage #(
        .PC_RESET (BASE),
        .IM_DEPTH (1024),
        .IM_INIT  (TB_ROM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .npc_op    (npc_op),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .j_index   (j_index),
        .jr_target (jr_target),
        .f_pc      (f_pc),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_pc8     (d_pc8)
    );

    always #5 clk = ~clk;

    // Reference model: state of the fetch/decode boundary as the rules define it.
    logic [31:0] m_fpc, m_dinstr, m_dpc, m_dpc8;

    function automatic logic [31:0] rom_at(input logic [31:0] addr);
        longint unsigned a;
        a = longint'(addr);
        if (a >= 64'h3000 && a < 64'h3000 + 4 * 1024 && (a % 4) == 0)
            return TB_ROM[int'((a - 64'h3000) / 4)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_next_pc();
        logic [31:0] seq, link4, disp;
        seq   = m_fpc + 32'd4;
        link4 = m_dpc + 32'd4;
        disp  = 32'($signed(br_off)) * 32'd4;
        if (npc_op == 2'd1 && br_taken) return link4 + disp;
        if (npc_op == 2'd2) return (link4 & 32'hf000_0000) | (32'(j_index) * 32'd4);
        if (npc_op == 2'd3) return jr_target;
        return seq;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_fpc    <= BASE;
            m_dinstr <= 32'h0;
            m_dpc    <= BASE;
            m_dpc8   <= BASE + 32'd8;
        end else if (!stall) begin
            m_fpc    <= model_next_pc();
            m_dinstr <= flush ? 32'h0 : rom_at(m_fpc);
            m_dpc    <= m_fpc;
            m_dpc8   <= m_fpc + 32'd8;
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp("model_f_pc", f_pc, m_fpc);
            cmp("model_d_instr", d_instr, m_dinstr);
            cmp("model_d_pc", d_pc, m_dpc);
            cmp("model_d_pc8", d_pc8, m_dpc8);
        end
    end

    task automatic step(input logic [1:0] op, input logic tk, input logic [15:0] off,
                        input logic [25:0] ji, input logic [31:0] jt,
                        input logic st, input logic fl, input logic rs);
        npc_op = op; br_taken = tk; br_off = off; j_index = ji; jr_target = jt;
        stall = st; flush = fl; reset = rs;
        @(posedge clk);
        @(negedge clk);
        $display("txn op=%0d tk=%0b st=%0b fl=%0b rs=%0b -> f_pc=%h d_instr=%h d_pc=%h d_pc8=%h",
                 op, tk, st, fl, rs, f_pc, d_instr, d_pc, d_pc8);
    endtask

    task automatic seq();
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jr(input logic [31:0] t);
        step(2'd3, 1'b0, 16'h0, 26'h0, t, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; npc_op = 2'd0; br_taken = 1'b0;
        br_off = 16'h0; j_index = 26'h0; jr_target = 32'h0;
        @(negedge clk);

        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        checking = 1'b1;
        cmp("rst_f_pc", f_pc, 32'h3000);
        cmp("rst_d_instr", d_instr, 32'h0);
        cmp("rst_d_pc", d_pc, 32'h3000);
        cmp("rst_d_pc8", d_pc8, 32'h3008);

        seq();
        cmp("seq1_f_pc", f_pc, 32'h3004);
        cmp("seq1_d_instr", d_instr, 32'h3c010001);
        cmp("seq1_d_pc8", d_pc8, 32'h3008);
        seq();
        cmp("seq2_f_pc", f_pc, 32'h3008);
        cmp("seq2_d_instr", d_instr, 32'h34210002);
        cmp("seq2_d_pc", d_pc, 32'h3004);
        cmp("seq2_d_pc8", d_pc8, 32'h300c);
        seq();
        cmp("seq3_f_pc", f_pc, 32'h300c);
        cmp("pin_model_f_pc", m_fpc, 32'h300c);

        // Taken backward branch at 3008; delay slot 300c still enters D.
        step(2'd1, 1'b1, 16'hfffe, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cmp("br_f_pc", f_pc, 32'h3004);
        cmp("br_slot_d_pc", d_pc, 32'h300c);
        cmp("br_slot_d_instr", d_instr, 32'h1000fffe);
        seq();
        step(2'd1, 1'b0, 16'hfffe, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cmp("nt_f_pc", f_pc, 32'h300c);
        seq();
        seq();
        cmp("pre_j_d_pc", d_pc, 32'h3010);

        step(2'd2, 1'b0, 16'h0, 26'h0000c10, 32'h0, 1'b0, 1'b0, 1'b0);
        cmp("j_f_pc", f_pc, 32'h3040);
        cmp("pin_model_j", m_fpc, 32'h3040);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h301c, 1'b1, 1'b0, 1'b0);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h301c, 1'b1, 1'b0, 1'b0);
        cmp("stall_f_pc", f_pc, 32'h3040);
        cmp("stall_d_pc", d_pc, 32'h3014);
        cmp("stall_d_instr", d_instr, 32'h24000005);
        jr(32'h301c);
        cmp("jr_f_pc", f_pc, 32'h301c);
        cmp("jr_d_instr", d_instr, 32'h24000010);

        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cmp("flush_d_instr", d_instr, 32'h0);
        cmp("flush_d_pc", d_pc, 32'h301c);
        cmp("flush_f_pc", f_pc, 32'h3020);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        cmp("stfl_f_pc", f_pc, 32'h3020);
        cmp("stfl_d_pc", d_pc, 32'h301c);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        cmp("rststall_f_pc", f_pc, 32'h3000);
        cmp("rststall_d_instr", d_instr, 32'h0);

        jr(32'h00002ffc);
        cmp("oor_lo_f_pc", f_pc, 32'h2ffc);
        jr(32'h00004000);
        cmp("oor_lo_d_instr", d_instr, 32'h0);
        jr(32'h00003ffc);
        cmp("oor_hi_d_instr", d_instr, 32'h0);
        cmp("oor_hi_d_pc", d_pc, 32'h4000);
        jr(32'h00003002);
        cmp("last_word_d_instr", d_instr, 32'hdeadbeef);
        jr(32'hfffffffc);
        cmp("misalign_d_instr", d_instr, 32'h0);
        seq();
        cmp("wrap_f_pc", f_pc, 32'h0);
        cmp("wrap_d_pc8", d_pc8, 32'h4);
        seq();
        cmp("zero_d_instr", d_instr, 32'h0);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
